// File: rtl/reg_writeback_arbiter.sv
// Writer-side front end for the integer register file.
// Merges single-cycle ALU results and buffered LSU results into one write port.
// ALU results win arbitration unless the LSU FIFO has waited MAX_WAIT cycles.
// A combinational busy lookup reports registers with writes still in flight.
module reg_writeback_arbiter #(
  parameter int REG_DATA_WIDTH_POW = 6,
  parameter int REG_MEM_DEPTH_POW  = 5,
  parameter int FIFO_DEPTH_POW     = 2,
  parameter int MAX_WAIT           = 4
) (
  input  logic                                clk_in,
  input  logic                                reset,
  input  logic                                alu_valid,
  output logic                                alu_ready,
  input  logic [REG_MEM_DEPTH_POW-1:0]        alu_rd,
  input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  alu_data,
  input  logic                                lsu_valid,
  output logic                                lsu_ready,
  input  logic [REG_MEM_DEPTH_POW-1:0]        lsu_rd,
  input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  lsu_data,
  output logic [REG_MEM_DEPTH_POW-1:0]        rd_out,
  output logic [(1<<REG_DATA_WIDTH_POW)-1:0]  data_write_out,
  output logic                                write_en_out,
  input  logic [REG_MEM_DEPTH_POW-1:0]        chk_rs1,
  input  logic [REG_MEM_DEPTH_POW-1:0]        chk_rs2,
  output logic                                busy1,
  output logic                                busy2,
  output logic [FIFO_DEPTH_POW:0]             fifo_count
);

  localparam int DATA_W = 1 << REG_DATA_WIDTH_POW;
  localparam int DEPTH  = 1 << FIFO_DEPTH_POW;
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [FIFO_DEPTH_POW:0]   CNT_FULL = (FIFO_DEPTH_POW+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_POW:0]   CNT_ONE  = (FIFO_DEPTH_POW+1)'(1);
  localparam logic [FIFO_DEPTH_POW-1:0] PTR_ONE  = FIFO_DEPTH_POW'(1);
  localparam logic [WAIT_W-1:0]         WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0]         WAIT_ONE = WAIT_W'(1);

  // LSU result storage; data words carry no reset, only pointers and count do
  logic [REG_MEM_DEPTH_POW-1:0] fifo_rd   [DEPTH];
  logic [DATA_W-1:0]            fifo_data [DEPTH];
  logic [FIFO_DEPTH_POW-1:0]    head;
  logic [FIFO_DEPTH_POW-1:0]    tail;
  logic [WAIT_W-1:0]            wait_cnt;

  // Arbitration stage (p0) signals
  logic                         force_fifo;
  logic                         alu_grant;
  logic                         fifo_grant;
  logic                         push;
  logic                         vld_p0;
  logic [REG_MEM_DEPTH_POW-1:0] grant_rd_p0;
  logic [DATA_W-1:0]            grant_data_p0;

  // Busy lookup helpers
  logic [FIFO_DEPTH_POW-1:0]    offs;
  logic                         hit1;
  logic                         hit2;

  // ---- stage p0: arbitration between ALU and FIFO head ----

  // Decide who owns the write port this cycle and what gets pushed
  always_comb begin
    force_fifo    = (fifo_count != '0) && (wait_cnt == WAIT_MAX);
    alu_ready     = !reset && !force_fifo;
    lsu_ready     = !reset && (fifo_count != CNT_FULL);
    alu_grant     = alu_valid && alu_ready;
    fifo_grant    = !reset && !alu_grant && (fifo_count != '0);
    push          = lsu_valid && lsu_ready && (lsu_rd != '0);
    vld_p0        = alu_grant || fifo_grant;
    grant_rd_p0   = alu_rd;
    grant_data_p0 = alu_data;
    if (!alu_grant) begin
      grant_rd_p0   = fifo_rd[head];
      grant_data_p0 = fifo_data[head];
    end
  end

  // Scan valid FIFO slots for the two queried registers
  always_comb begin
    offs = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = FIFO_DEPTH_POW'(i) - head;
      if ({1'b0, offs} < fifo_count) begin
        if (fifo_rd[i] == chk_rs1) hit1 = 1'b1;
        if (fifo_rd[i] == chk_rs2) hit2 = 1'b1;
      end
    end
    busy1 = (chk_rs1 != '0) && (hit1 || (write_en_out && (rd_out == chk_rs1)));
    busy2 = (chk_rs2 != '0) && (hit2 || (write_en_out && (rd_out == chk_rs2)));
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk_in) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
    end else begin
      if (push)       tail <= tail + PTR_ONE;
      if (fifo_grant) head <= head + PTR_ONE;
      case ({push, fifo_grant})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Write the accepted LSU result at the tail slot
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_rd[tail]   <= lsu_rd;
      fifo_data[tail] <= lsu_data;
    end
  end

  // Anti-starvation counter: counts cycles a non-empty FIFO is passed over
  always_ff @(posedge clk_in) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((fifo_count == '0) || fifo_grant) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + WAIT_ONE;
    end
  end

  // ---- stage p1: registered write port to the register file ----

  // Latch the granted write; x0 destinations are consumed without a write
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_out         <= '0;
      data_write_out <= '0;
      write_en_out   <= 1'b0;
    end else if (vld_p0) begin
      rd_out         <= grant_rd_p0;
      data_write_out <= grant_data_p0;
      write_en_out   <= (grant_rd_p0 != '0);
    end else begin
      write_en_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Randomized scoreboard bench for reg_writeback_arbiter.
// A queue-based reference model predicts ready/busy/count each cycle and
// the register-file writes; a monitor pops expected writes as they appear.
module tb_reg_writeback_arbiter;

  localparam int MAXW = 4;

  logic        clk_in;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic [4:0]  rd_out;
  logic [63:0] data_write_out;
  logic        write_en_out;
  logic [4:0]  chk_rs1, chk_rs2;
  logic        busy1, busy2;
  logic [2:0]  fifo_count;

  reg_writeback_arbiter #(
    .REG_DATA_WIDTH_POW(6), .REG_MEM_DEPTH_POW(5), .FIFO_DEPTH_POW(2), .MAX_WAIT(MAXW)
  ) dut (
    .clk_in(clk_in), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rd_out(rd_out), .data_write_out(data_write_out), .write_en_out(write_en_out),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy1(busy1), .busy2(busy2),
    .fifo_count(fifo_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed { logic [4:0] rd; logic [63:0] data; } ent_t;
  typedef struct { logic [4:0] rd; logic [63:0] data; int due; } exp_t;

  ent_t mq[$];         // model of buffered LSU results, oldest first
  exp_t sb[$];         // expected register-file writes
  int   mwait;
  logic m_we;
  logic [4:0] m_rd;
  int   ncyc;
  int   n_total;
  int   n_pass;
  logic last_alu_stall, last_lsu_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
  endtask

  function automatic logic busy_ref(input logic [4:0] c);
    if (c == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == c) return 1'b1;
    return m_we && (m_rd == c);
  endfunction

  // One clock cycle: drive, check combinational outputs, advance the model
  task automatic step(input logic rst, input logic av, input logic [4:0] ard,
                      input logic [63:0] ad, input logic lv, input logic [4:0] lrd,
                      input logic [63:0] ld, input logic [4:0] c1, input logic [4:0] c2);
    int sz;
    logic e_ar, e_lr, g;
    logic [4:0] grd;
    logic [63:0] gd;
    ent_t e;
    bit fg;
    @(negedge clk_in);
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; chk_rs1 = c1; chk_rs2 = c2;
    #1;
    sz = mq.size();
    if (rst) begin
      e_ar = 1'b0; e_lr = 1'b0;
    end else begin
      e_ar = !((sz != 0) && (mwait == MAXW));
      e_lr = (sz != 4);
    end
    chk("alu_ready", alu_ready, e_ar);
    chk("lsu_ready", lsu_ready, e_lr);
    chk("fifo_count", fifo_count, sz);
    chk("busy1", busy1, busy_ref(c1));
    chk("busy2", busy2, busy_ref(c2));
    last_alu_stall = av && !e_ar;
    last_lsu_stall = lv && !e_lr;
    if (rst) begin
      mq.delete(); mwait = 0; m_we = 1'b0; m_rd = 5'd0;
      return;
    end
    g = 1'b0; fg = 1'b0; grd = 5'd0; gd = 64'd0;
    if (av && e_ar) begin
      g = 1'b1; grd = ard; gd = ad;
    end else if (sz != 0) begin
      e = mq.pop_front(); g = 1'b1; fg = 1'b1; grd = e.rd; gd = e.data;
    end
    if (sz == 0 || fg) mwait = 0;
    else if (mwait < MAXW) mwait++;
    if (lv && e_lr && lrd != 5'd0) mq.push_back('{lrd, ld});
    if (g) begin
      m_we = (grd != 5'd0); m_rd = grd;
      if (grd != 5'd0) sb.push_back('{rd: grd, data: gd, due: ncyc + 1});
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic idle(input logic [4:0] c1);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, c1, 5'd0);
  endtask

  // Monitor: every write seen on the port must match the next expected one
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_in);
      #1;
      ncyc++;
      if (write_en_out === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_write_en", write_en_out, 1'b0);
        end else begin
          x = sb.pop_front();
          chk("wr_rd", rd_out, x.rd);
          chk("wr_data", data_write_out, x.data);
          chk("wr_cycle", ncyc, x.due);
        end
      end else if (sb.size() != 0 && sb[0].due <= ncyc) begin
        x = sb.pop_front();
        chk("missing_write_en", write_en_out, 1'b1);
      end
    end
  end

  initial begin
    logic r_av, r_lv;
    logic [4:0] r_ard, r_lrd;
    logic [63:0] r_ad, r_ld;
    int apct;
    ncyc = 0; n_total = 0; n_pass = 0; mwait = 0; m_we = 1'b0; m_rd = 5'd0;
    last_alu_stall = 1'b0; last_lsu_stall = 1'b0;
    reset = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 64'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 64'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;

    // Reset state
    step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    chk("rst_rd_out", rd_out, 5'd0);
    chk("rst_data_out", data_write_out, 64'd0);
    chk("rst_write_en", write_en_out, 1'b0);

    // Simple ALU write, then LSU write
    step(1'b0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
    idle(5'd5);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hAA, 5'd7, 5'd0);
    idle(5'd7); idle(5'd7); idle(5'd7);

    // ALU saturates the port while the LSU waits for a forced grant
    step(1'b0, 1'b1, 5'd3, 64'h33, 1'b1, 5'd9, 64'h99, 5'd9, 5'd3);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0, 5'd9, 5'd3);

    // Fill the FIFO with rd 1..4 under ALU pressure, then drain and wrap
    for (int i = 1; i <= 4; i++)
      step(1'b0, 1'b1, 5'd3, 64'h33, 1'b1, 5'(i), 64'(i * 16), 5'(i), 5'd4);
    step(1'b0, 1'b1, 5'd3, 64'h33, 1'b1, 5'd6, 64'h66, 5'd1, 5'd6);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0, 5'd4, 5'd6);
    for (int i = 0; i < 6; i++) idle(5'd6);

    // x0 destinations are consumed without any write
    step(1'b0, 1'b1, 5'd0, 64'hDEAD, 1'b1, 5'd0, 64'hBEEF, 5'd0, 5'd0);
    idle(5'd0); idle(5'd0);

    // Reset with three entries buffered discards them
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 5'd3, 64'h33, 1'b1, 5'(12 + i), 64'(i), 5'd12, 5'd14);
    step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd12, 5'd14);
    idle(5'd12);
    chk("post_rst_write_en", write_en_out, 1'b0);

    // Randomized traffic in phases of differing ALU pressure
    r_av = 1'b0; r_lv = 1'b0; r_ard = 5'd0; r_lrd = 5'd0; r_ad = 64'd0; r_ld = 64'd0;
    for (int ph = 0; ph < 3; ph++) begin
      apct = (ph == 0) ? 90 : (ph == 1) ? 50 : 15;
      for (int i = 0; i < 600; i++) begin
        if (!last_alu_stall) begin
          r_av  = ($urandom_range(0, 99) < apct);
          r_ard = 5'($urandom_range(0, 7));
          r_ad  = {$urandom, $urandom};
        end
        if (!last_lsu_stall) begin
          r_lv  = ($urandom_range(0, 99) < 55);
          r_lrd = 5'($urandom_range(0, 7));
          r_ld  = {$urandom, $urandom};
        end
        step(($urandom_range(0, 249) == 0), r_av, r_ard, r_ad, r_lv, r_lrd, r_ld,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end

    for (int i = 0; i < 12; i++) idle(5'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_writeback_arbiter.md
Name: reg_writeback_arbiter

Overview:
Writer-side front end for the integer register file. Merges results from the single-cycle ALU and the variable-latency load/store unit (LSU) into the file's single write port (rd, data, write_en). ALU results have priority; LSU results are buffered in an in-order FIFO with an anti-starvation counter. A combinational busy lookup lets issue logic stall on registers with writes still in flight.

Parameters:
REG_DATA_WIDTH_POW, 6, log2 of data width (data width = 1<<POW = 64)
REG_MEM_DEPTH_POW, 5, log2 of register count (register index width = 5)
FIFO_DEPTH_POW, 2, log2 of LSU FIFO depth (depth = 4)
MAX_WAIT, 4, consecutive cycles a non-empty FIFO may go ungranted before it is forced

Ports:
clk_in  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
alu_valid  in  1  ALU result present this cycle
alu_ready  out  1  ALU result accepted this cycle (combinational)
alu_rd  in  REG_MEM_DEPTH_POW  ALU destination register
alu_data  in  REG_DATA_WIDTH  ALU result
lsu_valid  in  1  LSU result present
lsu_ready  out  1  FIFO can accept (combinational)
lsu_rd  in  REG_MEM_DEPTH_POW  LSU destination register
lsu_data  in  REG_DATA_WIDTH  LSU result
rd_out  out  REG_MEM_DEPTH_POW  to register file rd_in (registered)
data_write_out  out  REG_DATA_WIDTH  to register file data_write (registered)
write_en_out  out  1  to register file write_en (registered)
chk_rs1, chk_rs2  in  REG_MEM_DEPTH_POW  registers queried for pending writes
busy1, busy2  out  1  pending write exists for chk_rs1 / chk_rs2 (combinational)
fifo_count  out  FIFO_DEPTH_POW+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high; clock clk_in): FIFO emptied, fifo_count=0, wait_cnt=0, rd_out=0, data_write_out=0, write_en_out=0. While reset is high, alu_ready=0 and lsu_ready=0.
- Handshake: a transfer occurs when valid && ready in the same cycle. Producers hold rd/data stable while valid && !ready.
- lsu_ready = (fifo_count != 1<<FIFO_DEPTH_POW); it does not depend on a same-cycle pop. When full, lsu_ready=0 even if a pop occurs that cycle.
- LSU push: on an accepted transfer with lsu_rd==0, the transfer is consumed but nothing is stored. Otherwise the result is pushed at the FIFO tail.
- Arbitration, evaluated each cycle:
  - force = (fifo_count!=0) && (wait_cnt==MAX_WAIT).
  - alu_ready = !force.
  - Grant goes to the ALU if alu_valid && !force.
  - Otherwise grant goes to the FIFO head if the FIFO is non-empty.
  - Otherwise there is no grant.
- wait_cnt:
  - Reset to 0 when the FIFO is granted or the FIFO is empty.
  - Incremented when the FIFO is non-empty and not granted.
  - Saturates at MAX_WAIT.
- Output register (1-cycle latency): on a grant, the granted rd and data are latched into rd_out/data_write_out, and write_en_out <= (granted rd != 0).
  - ALU results with alu_rd==0 are accepted and dropped (write_en_out=0).
  - With no grant, write_en_out <= 0 and rd_out/data_write_out hold their values.
- FIFO pop on grant. Push and pop in the same cycle leave the count unchanged. An LSU result pushed in cycle T is poppable no earlier than T+1, so write_en_out rises at the earliest at edge T+2.
- FIFO order is strictly in order. Head/tail pointers are FIFO_DEPTH_POW bits wide and wrap modulo depth.
- busy1 = (chk_rs1!=0) && (any valid FIFO entry has rd==chk_rs1 || (write_en_out && rd_out==chk_rs1)). busy2 is the same for chk_rs2. The output register counts as pending because the register file commits it at the next edge.
- The block does not resolve WAW between ALU and LSU for the same rd. Issue logic must stall on busy.
- Reset mid-operation discards all buffered and in-flight writes. write_en_out is 0 from the first post-reset cycle.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0x1234 -> alu_ready=1; next cycle write_en_out=1, rd_out=5, data_write_out=0x1234.
- ALU idle; LSU pushes rd=7, data=0xAA at cycle T -> fifo_count=1 at T+1; write_en_out=1, rd_out=7 at T+2; fifo_count=0.
- alu_valid held high with alu_rd=3 continuously while LSU pushes rd=9 -> after 4 ungranted cycles alu_ready=0 for one cycle; rd_out=9, write_en_out=1 the following cycle; ALU resumes.
- LSU pushes 4 entries (rd 1..4) while ALU saturates -> fifo_count=4, lsu_ready=0; entries drain in order 1,2,3,4 with forced grants; pointers wrap correctly on the next push.
- alu_rd=0 / lsu_rd=0 transfers -> accepted, write_en_out stays 0, fifo_count unchanged for LSU; chk_rs1=0 -> busy1=0 always.
- FIFO holds rd=12, chk_rs1=12 -> busy1=1 until the cycle after write_en_out for rd 12 deasserts. Asserting reset with 3 entries buffered -> fifo_count=0, write_en_out=0, busy1=0 next cycle.
